// File: rtl/ex_fsm_mc.sv
// ex_fsm_mc: CH independent glitch-filtered IDLE->START->STOP->CLEAR sequencers with per-state timeout.
// Defining EX_FSM_MC_CNT_EN builds per-channel 8-bit completed-cycle counters on cyc_cnt.
module ex_fsm_mc #(
   parameter int CH       = 4,
   parameter int FILT_CYC = 3,
   parameter int TMO_CYC  = 1000,
   parameter int TMO_W    = 16
) (
   input  logic            sclk,
   input  logic            rst_n,
   input  logic [CH-1:0]   A,
   output logic [CH-1:0]   k1,
   output logic [CH-1:0]   k2,
   output logic [CH-1:0]   done,
   output logic [CH-1:0]   tmo,
   output logic [CH-1:0]   busy,
   output logic [CH*8-1:0] cyc_cnt
);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      STOP  = 4'b0100,
      CLEAR = 4'b1000
   } state_e;

   localparam int FC_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_e state_q, state_d;
      logic   k1_q, k1_d, k2_q, k2_d;
      logic   done_q, done_d, tmo_q, tmo_d, busy_q, busy_d;
      logic   aq_s, trans_s, active_s, tmo_hit_s;

      if (FILT_CYC == 0) begin : g_nofilt
         assign aq_s = A[i];
      end else begin : g_filt
         logic            aq_q, aq_d;
         logic [FC_W-1:0] fc_q, fc_d;

         // A change on A is accepted only after FILT_CYC consecutive differing samples
         always_comb begin
            aq_d = aq_q;
            fc_d = fc_q;
            if (A[i] != aq_q) begin
               if (fc_q == FC_W'(FILT_CYC - 1)) begin
                  aq_d = A[i];
                  fc_d = {FC_W{1'b0}};
               end else begin
                  fc_d = fc_q + FC_W'(1);
               end
            end else begin
               fc_d = {FC_W{1'b0}};
            end
         end

         always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) begin
               aq_q <= 1'b0;
               fc_q <= {FC_W{1'b0}};
            end else begin
               aq_q <= aq_d;
               fc_q <= fc_d;
            end
         end

         assign aq_s = aq_q;
      end

      // Legal-transition request for the current state; an illegal encoding never requests one
      always_comb begin
         case (state_q)
            IDLE:    trans_s = aq_s;
            START:   trans_s = ~aq_s;
            STOP:    trans_s = aq_s;
            CLEAR:   trans_s = ~aq_s;
            default: trans_s = 1'b0;
         endcase
      end

      assign active_s = (state_q == START) || (state_q == STOP) || (state_q == CLEAR);

      if (TMO_CYC > 0) begin : g_tmo
         logic [TMO_W-1:0] tc_q, tc_d;

         // A legal transition in the expiry cycle takes priority over the timeout
         assign tmo_hit_s = active_s && !trans_s && (tc_q == TMO_W'(TMO_CYC - 1));

         always_comb begin
            if ((state_d != state_q) || (state_q == IDLE)) begin
               tc_d = {TMO_W{1'b0}};
            end else begin
               tc_d = tc_q + TMO_W'(1);
            end
         end

         always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) begin
               tc_q <= {TMO_W{1'b0}};
            end else begin
               tc_q <= tc_d;
            end
         end
      end else begin : g_notmo
         assign tmo_hit_s = 1'b0;
      end

      always_comb begin
         state_d = state_q;
         k1_d    = k1_q;
         k2_d    = k2_q;
         done_d  = 1'b0;
         tmo_d   = 1'b0;
         if (tmo_hit_s) begin
            state_d = IDLE;
            k1_d    = 1'b0;
            k2_d    = 1'b0;
            tmo_d   = 1'b1;
         end else if (trans_s) begin
            case (state_q)
               IDLE: begin
                  state_d = START;
                  k1_d    = 1'b0;
               end
               START: state_d = STOP;
               STOP: begin
                  state_d = CLEAR;
                  k1_d    = 1'b1;
                  k2_d    = 1'b1;
               end
               CLEAR: begin
                  state_d = IDLE;
                  k2_d    = 1'b0;
                  done_d  = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end else if (!active_s && (state_q != IDLE)) begin
            state_d = IDLE;
         end else begin
            state_d = state_q;
         end
      end

      assign busy_d = (state_d != IDLE);

      always_ff @(posedge sclk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= IDLE;
            k1_q    <= 1'b0;
            k2_q    <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
         end
      end

      assign k1[i]   = k1_q;
      assign k2[i]   = k2_q;
      assign done[i] = done_q;
      assign tmo[i]  = tmo_q;
      assign busy[i] = busy_q;

`ifdef EX_FSM_MC_CNT_EN
      logic [7:0] cnt_q, cnt_d;

      // Only completed sequences count; the 8-bit counter wraps naturally
      always_comb begin
         if (done_d) begin
            cnt_d = cnt_q + 8'd1;
         end else begin
            cnt_d = cnt_q;
         end
      end

      always_ff @(posedge sclk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= 8'd0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cyc_cnt[8*i +: 8] = cnt_q;
`else
      assign cyc_cnt[8*i +: 8] = 8'd0;
`endif
   end

endmodule

// File: tb/tb_ex_fsm_mc.sv
// Directed, table-driven bench for ex_fsm_mc: filtered sequence, glitch, timeout, parallel channels,
// asynchronous mid-sequence reset and the optional completed-cycle counter.
module tb_ex_fsm_mc;

`ifdef EX_FSM_MC_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        sclk  = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  a_a, a_b;
   logic [1:0]  a_c;
   logic [3:0]  k1_a, k2_a, done_a, tmo_a, busy_a;
   logic [3:0]  k1_b, k2_b, done_b, tmo_b, busy_b;
   logic [1:0]  k1_c, k2_c, done_c, tmo_c, busy_c;
   logic [31:0] cyc_a, cyc_b;
   logic [15:0] cyc_c;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic p;
      logic k1;
      logic k2;
      logic dn;
      logic b;
   } vec_t;

   vec_t tbl [19];

   always #5 sclk = ~sclk;

   // Filtered, no timeout
   ex_fsm_mc #(.CH(4), .FILT_CYC(3), .TMO_CYC(0), .TMO_W(16)) dut_a (
      .sclk(sclk), .rst_n(rst_n), .A(a_a), .k1(k1_a), .k2(k2_a),
      .done(done_a), .tmo(tmo_a), .busy(busy_a), .cyc_cnt(cyc_a));

   // Filtered, timeout after 10 cycles
   ex_fsm_mc #(.CH(4), .FILT_CYC(3), .TMO_CYC(10), .TMO_W(16)) dut_b (
      .sclk(sclk), .rst_n(rst_n), .A(a_b), .k1(k1_b), .k2(k2_b),
      .done(done_b), .tmo(tmo_b), .busy(busy_b), .cyc_cnt(cyc_b));

   // Filter bypassed, short timeout, used for the long counter run
   ex_fsm_mc #(.CH(2), .FILT_CYC(0), .TMO_CYC(5), .TMO_W(4)) dut_c (
      .sclk(sclk), .rst_n(rst_n), .A(a_c), .k1(k1_c), .k2(k2_c),
      .done(done_c), .tmo(tmo_c), .busy(busy_c), .cyc_cnt(cyc_c));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic c_cycle();
      a_c = 2'b10; tick();
      a_c = 2'b00; tick();
      a_c = 2'b10; tick();
      a_c = 2'b00; tick();
   endtask

   function automatic vec_t mk(input logic p, input logic k1, input logic k2, input logic dn, input logic b);
      vec_t v;
      v.p = p; v.k1 = k1; v.k2 = k2; v.dn = dn; v.b = b;
      return v;
   endfunction

   initial begin
      logic [3:0] e_k1, e_k2, e_dn, e_tmo, e_b;

      // Rows 1-14: full sequence (A held 3 cycles per level); rows 15-19: 2-cycle glitch in IDLE
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[17] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      a_a = 4'h0; a_b = 4'h0; a_c = 2'b00;
      #12;
      check("reset_a", {k1_a, k2_a, done_a, tmo_a, busy_a, cyc_a}, 64'd0);
      check("reset_b", {k1_b, k2_b, done_b, tmo_b, busy_b, cyc_b}, 64'd0);
      check("reset_c", {k1_c, k2_c, done_c, tmo_c, busy_c, cyc_c}, 64'd0);
      rst_n = 1'b1;
      tick();

      // ch0/ch3 identical sequences, ch1 idle, ch2 parked in START with timeout disabled
      for (int i = 0; i < 19; i++) begin
         a_a   = {tbl[i].p, 1'b1, 1'b0, tbl[i].p};
         tick();
         e_k1  = {tbl[i].k1, 2'b00, tbl[i].k1};
         e_k2  = {tbl[i].k2, 2'b00, tbl[i].k2};
         e_dn  = {tbl[i].dn, 2'b00, tbl[i].dn};
         e_tmo = 4'h0;
         e_b   = {tbl[i].b, (i >= 3), 1'b0, tbl[i].b};
         check($sformatf("seq_row%0d", i + 1), {k1_a, k2_a, done_a, tmo_a, busy_a},
               {e_k1, e_k2, e_dn, e_tmo, e_b});
      end
      check("cnt_after_seq", cyc_a, CNT_ON ? 32'h0100_0001 : 32'h0);
      check("b_idle", {k1_b, busy_b, tmo_b}, 12'h000);

      // Drive ch0 into CLEAR, then reset asynchronously between clock edges
      a_a = 4'b0001; repeat (3) tick();
      a_a = 4'b0000; repeat (3) tick();
      a_a = 4'b0001; repeat (4) tick();
      check("rst_pre_clear", {k1_a[0], k2_a[0], busy_a[0]}, 3'b111);
      #2 rst_n = 1'b0;
      #1 check("rst_async", {k1_a, k2_a, done_a, tmo_a, busy_a}, 20'h0);
      #2 rst_n = 1'b1;
      tick();
      check("rst_idle", busy_a, 4'h0);
      tick(); tick();
      check("rst_fresh_edge", busy_a, 4'h0);
      tick();
      check("rst_restart", busy_a, 4'b0001);
      a_a = 4'h0;

      // Timeout in START on dut_b ch0 (entry at cycle 4, expiry at cycle 14), then a clean new run
      for (int e = 1; e <= 24; e++) begin
         a_b = {3'b000, ((e <= 14) || ((e >= 18) && (e <= 20)))};
         tick();
         if (e == 13) begin
            check("tmo_before", {tmo_b, busy_b}, {4'h0, 4'h1});
         end else if (e == 14) begin
            check("tmo_hit", {k1_b, k2_b, done_b, tmo_b, busy_b}, {4'h0, 4'h0, 4'h0, 4'h1, 4'h0});
         end else if (e == 15) begin
            check("tmo_single", {tmo_b, busy_b}, {4'h0, 4'h1});
         end else if (e == 21) begin
            check("tmo_new_clear", {k1_b, k2_b, busy_b}, {4'h1, 4'h1, 4'h1});
         end else if (e == 24) begin
            check("tmo_new_done", {k1_b, k2_b, done_b, tmo_b, busy_b}, {4'h1, 4'h0, 4'h1, 4'h0, 4'h0});
         end
      end

      a_b = 4'h0;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;

      // Parallel: ch0/ch3 full runs, ch1 idle, ch2 stuck in STOP from cycle 7 until timeout at 17
      for (int i = 0; i < 19; i++) begin
         a_b   = {tbl[i].p, (i < 3), 1'b0, tbl[i].p};
         tick();
         e_k1  = {tbl[i].k1, 2'b00, tbl[i].k1};
         e_k2  = {tbl[i].k2, 2'b00, tbl[i].k2};
         e_dn  = {tbl[i].dn, 2'b00, tbl[i].dn};
         e_tmo = {1'b0, (i == 16), 2'b00};
         e_b   = {tbl[i].b, ((i >= 3) && (i <= 15)), 1'b0, tbl[i].b};
         check($sformatf("par_row%0d", i + 1), {k1_b, k2_b, done_b, tmo_b, busy_b},
               {e_k1, e_k2, e_dn, e_tmo, e_b});
      end
      a_b = 4'h0;

      // Unfiltered channel: one edge per transition
      a_c = 2'b10; tick();
      check("nf_start", {k1_c, busy_c}, {2'b00, 2'b10});
      a_c = 2'b00; tick();
      a_c = 2'b10; tick();
      check("nf_clear", {k1_c, k2_c, busy_c}, {2'b10, 2'b10, 2'b10});
      a_c = 2'b00; tick();
      check("nf_done", {done_c, k2_c, k1_c, busy_c}, {2'b10, 2'b00, 2'b10, 2'b00});
      tick();
      check("nf_done_pulse", done_c, 2'b00);

      for (int n = 0; n < 254; n++) c_cycle();
      check("cnt_255", cyc_c, CNT_ON ? 16'hFF00 : 16'h0000);
      c_cycle();
      check("cnt_wrap", cyc_c, 16'h0000);

      // Timeout on ch1 of dut_c (TMO_CYC=5) must not count
      a_c = 2'b10;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 5) begin
            check("c_tmo_before", {tmo_c, busy_c}, {2'b00, 2'b10});
         end else if (e == 6) begin
            check("c_tmo_hit", {k1_c, k2_c, done_c, tmo_c, busy_c}, {2'b00, 2'b00, 2'b00, 2'b10, 2'b00});
         end
      end
      a_c = 2'b00; tick();
      check("c_tmo_idle", {tmo_c, busy_c}, 4'h0);
      check("cnt_tmo_unchanged", cyc_c, 16'h0000);
      c_cycle();
      check("cnt_after_tmo", cyc_c, CNT_ON ? 16'h0100 : 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
